// File: rtl/dff_bank_arbiter_if.sv
// Request/grant and read-return bundle shared by the two requesters and the bank arbiter.
// The master side drives requests; the slave side (the arbiter) returns grants and read data.
interface dff_bank_arbiter_if #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ADDR_W = 2
);
    logic              req0;
    logic              req1;
    logic              lock0;
    logic              lock1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [WIDTH-1:0]  wdata0;
    logic [WIDTH-1:0]  wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              rd_valid;
    logic              rd_id;
    logic [WIDTH-1:0]  rd_data;
    logic              owner_vld;
    logic              owner_id;

    modport master (
        output req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1,
        input  gnt0, gnt1, rd_valid, rd_id, rd_data, owner_vld, owner_id
    );

    modport slave (
        input  req0, req1, lock0, lock1, we0, we1, addr0, addr1, wdata0, wdata1,
        output gnt0, gnt1, rd_valid, rd_id, rd_data, owner_vld, owner_id
    );
endinterface

// File: rtl/dff_bank_arbiter.sv
// Round-robin arbiter sharing a small flop-based register bank between two requesters,
// with optional bounded lock bursts and a one-cycle registered read return.
module dff_bank_arbiter #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned DEPTH     = 4,
    parameter int unsigned ADDR_W    = 2,
    parameter int unsigned MAX_BURST = 4
) (
    input logic               clk,
    input logic               rst_n,
    dff_bank_arbiter_if.slave bus
);
    localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        StIdle,
        StOwn0,
        StOwn1
    } state_e;

    state_e            state_q;
    logic              rr_ptr_q;
    logic [CNT_W-1:0]  burst_cnt_q;
    logic [WIDTH-1:0]  bank_q [DEPTH];

    logic              acc;
    logic              sel;
    logic              sel_lock;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [WIDTH-1:0]  sel_wdata;
    logic [IDX_W-1:0]  idx;
    logic              in_range;
    logic [CNT_W-1:0]  cnt_inc;
    logic              release_own;

    // Grants depend only on state, pointer and requests; reset forces them low.
    always_comb begin
        bus.gnt0 = 1'b0;
        bus.gnt1 = 1'b0;
        if (rst_n) begin
            unique case (state_q)
                StIdle: begin
                    if (bus.req0 && bus.req1) begin
                        bus.gnt0 = ~rr_ptr_q;
                        bus.gnt1 = rr_ptr_q;
                    end else begin
                        bus.gnt0 = bus.req0;
                        bus.gnt1 = bus.req1;
                    end
                end
                StOwn0:  bus.gnt0 = bus.req0;
                StOwn1:  bus.gnt1 = bus.req1;
                default: ;
            endcase
        end
    end

    always_comb begin
        acc       = (bus.req0 && bus.gnt0) || (bus.req1 && bus.gnt1);
        sel       = bus.req1 && bus.gnt1;
        sel_lock  = sel ? bus.lock1  : bus.lock0;
        sel_we    = sel ? bus.we1    : bus.we0;
        sel_addr  = sel ? bus.addr1  : bus.addr0;
        sel_wdata = sel ? bus.wdata1 : bus.wdata0;
        idx       = sel_addr[IDX_W-1:0];
        in_range  = 32'(sel_addr) < DEPTH;
        cnt_inc   = burst_cnt_q + CNT_W'(1);
        // In an own state the only possible acceptance is by the owner.
        release_own = !acc || !sel_lock || (32'(cnt_inc) >= MAX_BURST);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            rr_ptr_q      <= 1'b0;
            burst_cnt_q   <= '0;
            bank_q        <= '{default: '0};
            bus.rd_valid  <= 1'b0;
            bus.rd_id     <= 1'b0;
            bus.rd_data   <= '0;
            bus.owner_vld <= 1'b0;
            bus.owner_id  <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (acc) begin
                        if (sel_lock && (MAX_BURST > 1)) begin
                            state_q       <= sel ? StOwn1 : StOwn0;
                            burst_cnt_q   <= CNT_W'(1);
                            bus.owner_vld <= 1'b1;
                            bus.owner_id  <= sel;
                        end else begin
                            rr_ptr_q <= ~sel;
                        end
                    end
                end
                StOwn0, StOwn1: begin
                    if (release_own) begin
                        state_q       <= StIdle;
                        rr_ptr_q      <= (state_q == StOwn0);
                        burst_cnt_q   <= '0;
                        bus.owner_vld <= 1'b0;
                        bus.owner_id  <= 1'b0;
                    end else begin
                        burst_cnt_q <= cnt_inc;
                    end
                end
                default: state_q <= StIdle;
            endcase

            if (acc && sel_we && in_range) begin
                bank_q[idx] <= sel_wdata;
            end

            bus.rd_valid <= acc && !sel_we;
            if (acc && !sel_we) begin
                bus.rd_id   <= sel;
                bus.rd_data <= in_range ? bank_q[idx] : '0;
            end
        end
    end
endmodule

// File: doc/dff_bank_arbiter.md
Name: dff_bank_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one small D-flip-flop register bank between two requesters.
- Each cycle it grants at most one access (read or write). The grant is a combinational valid/ready handshake.
- A requester may lock the bank for a bounded burst.
- Read data returns one cycle after acceptance on a shared, registered read bus.

Parameters:
- WIDTH, 8, data word width in bits.
- DEPTH, 4, number of words in the bank.
- ADDR_W, 2, address width; must satisfy DEPTH <= 2**ADDR_W.
- MAX_BURST, 4, maximum consecutive accepted transactions under lock (>= 1).

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst_n  in  1  reset; synchronous, active-low.
- req0 / req1  in  1  request valid for requester 0 / 1.
- lock0 / lock1  in  1  when high with an accepted request, ownership is retained after this transaction.
- we0 / we1  in  1  1 = write, 0 = read.
- addr0 / addr1  in  ADDR_W  word address.
- wdata0 / wdata1  in  WIDTH  write data.
- gnt0 / gnt1  out  1  combinational grant; a transaction is accepted on an edge where reqX && gntX.
- rd_valid  out  1  registered pulse: read data valid this cycle.
- rd_id  out  1  requester that issued the returned read.
- rd_data  out  WIDTH  registered read data.
- owner_vld  out  1  high while in an OWN state.
- owner_id  out  1  current owner when owner_vld = 1, else 0.

Behaviour:
- Reset (edge sampled with rst_n = 0):
  - state = IDLE, rr_ptr = 0, burst_cnt = 0.
  - All bank words = 0.
  - rd_valid = 0, rd_id = 0, rd_data = 0.
  - gnt0 = gnt1 = 0 whenever rst_n = 0.
  - Reset overrides every other event, including a mid-burst or in-flight read: no bank write and no rd_valid on that edge.
- State IDLE:
  - Only one requesting: that requester is granted.
  - Both requesting: grant the requester equal to rr_ptr.
  - On acceptance by X with lockX = 0: rr_ptr <= ~X, stay in IDLE.
  - On acceptance by X with lockX = 1:
    - If MAX_BURST = 1: release immediately (rr_ptr <= ~X, stay in IDLE).
    - Otherwise: state <= OWNX, burst_cnt <= 1.
- State OWNX:
  - gntX = reqX; the other requester's grant is 0.
  - Accepted with lockX = 1 and burst_cnt+1 < MAX_BURST: burst_cnt increments, stay in OWNX.
  - Accepted with lockX = 0, or burst_cnt+1 == MAX_BURST: release. State <= IDLE, rr_ptr <= ~X, burst_cnt <= 0.
  - reqX = 0 in OWNX: release on that edge. No grant to anyone that cycle. rr_ptr <= ~X.
- Write: bank[addr] <= wdata on the accepting edge. A read accepted on the next cycle sees the new value.
- Read: on the accepting edge, rd_data <= bank[addr], rd_id <= X, rd_valid <= 1. Otherwise rd_valid <= 0 and rd_data/rd_id hold.
  - Latency is 1 cycle; back-to-back reads give consecutive rd_valid pulses.
- Address >= DEPTH: write ignored; read returns 0 with rd_valid = 1.
- Grants are purely a function of state, rr_ptr, burst_cnt and req. Other inputs need only be stable while reqX = 1.

Test Plan:
- Reset/idle: hold rst_n = 0 for 2 cycles with req0 = req1 = 1.
  -> gnt0 = gnt1 = 0, rd_valid = 0, owner_vld = 0.
  - After release with req1 = 1 only: gnt1 = 1 in the first cycle.
- Write/read: req0 write addr 2 data 0xA5, then req1 read addr 2 next cycle.
  -> rd_valid = 1, rd_id = 1, rd_data = 0xA5 one cycle after the read is accepted.
- Fairness: req0 = req1 = 1 continuously, no locks, 6 cycles.
  -> grants alternate 0,1,0,1,0,1 (rr_ptr = 0 after reset).
- Lock burst: req0 = lock0 = 1 with req1 = 1, MAX_BURST = 4.
  -> gnt0 for 4 consecutive cycles, owner_vld = 1 during cycles 2-4, then gnt1 on cycle 5 even with lock0 still high.
- Early release: in OWN0 drop req0 for one cycle.
  -> no grant that cycle, state IDLE next cycle, req1 granted next.
- Reset mid-burst: assert rst_n = 0 during OWN1 with a read in the same cycle.
  -> next cycle rd_valid = 0, owner_vld = 0, bank reads back all zeros.
